// File: rtl/play_button_anim_pkg.sv
// Shared constants, state encoding and slide helper for the PLAY-button title sprite.
package play_button_anim_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned WIDTH     = 133;
  localparam int unsigned HEIGHT    = 39;

  localparam int unsigned X_W   = 10;
  localparam int unsigned Y_W   = 9;
  localparam int unsigned CNT_W = 7;

  localparam int unsigned DEF_X_POS          = (H_VISIBLE - WIDTH) / 2;
  localparam int unsigned DEF_Y_START        = V_VISIBLE;
  localparam int unsigned DEF_Y_TARGET       = 300;
  localparam int unsigned DEF_SLIDE_STEP     = 4;
  localparam int unsigned DEF_BLINK_FRAMES   = 30;
  localparam int unsigned DEF_FLASH_FRAMES   = 4;
  localparam int unsigned DEF_CONFIRM_FRAMES = 60;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SLIDE_IN = 3'd1,
    ST_BLINK    = 3'd2,
    ST_CONFIRM  = 3'd3,
    ST_DONE     = 3'd4,
    ST_WAIT_CLR = 3'd5
  } state_t;

  // One slide step, clamped at target; done one bit wider so y < dec_step cannot wrap.
  function automatic logic [Y_W-1:0] slide_next(input logic [Y_W-1:0] y,
                                                input logic [Y_W-1:0] dec_step,
                                                input logic [Y_W-1:0] target);
    logic [Y_W:0] w_dec;
    w_dec = {1'b0, y} - {1'b0, dec_step};
    if (w_dec[Y_W] || (w_dec < {1'b0, target})) return target;
    return w_dec[Y_W-1:0];
  endfunction

endpackage

// File: rtl/play_button_anim_edge_pulse.sv
// Rising-edge detector with a registered history bit; the pulse itself is combinational.
module play_button_anim_edge_pulse #(
  parameter logic HIST_RST = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_pulse_c
);

  logic r_hist;

  always_ff @(posedge clk) begin
    if (rst) r_hist <= HIST_RST;
    else     r_hist <= i_sig;
  end

  assign o_pulse_c = i_sig & ~r_hist;

endmodule

// File: rtl/play_button_anim.sv
// Title-screen PLAY button sequencer: slide-in, blink, confirm flash, then a game_start pulse.
module play_button_anim
  import play_button_anim_pkg::*;
#(
  parameter int unsigned X_POS          = DEF_X_POS,
  parameter int unsigned Y_START        = DEF_Y_START,
  parameter int unsigned Y_TARGET       = DEF_Y_TARGET,
  parameter int unsigned SLIDE_STEP     = DEF_SLIDE_STEP,
  parameter int unsigned BLINK_FRAMES   = DEF_BLINK_FRAMES,
  parameter int unsigned FLASH_FRAMES   = DEF_FLASH_FRAMES,
  parameter int unsigned CONFIRM_FRAMES = DEF_CONFIRM_FRAMES
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           frame_tick,
  input  logic           enable,
  input  logic           start_key,
  output logic [X_W-1:0] posx,
  output logic [Y_W-1:0] posy,
  output logic           isplay,
  output logic           game_start,
  output logic           busy
);

  state_t           r_state, w_state_nxt;
  logic [X_W-1:0]   r_posx;
  logic [Y_W-1:0]   r_posy, w_posy_nxt;
  logic             r_isplay, w_isplay_nxt;
  logic             r_game_start, w_game_start_nxt;
  logic             r_busy;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [CNT_W-1:0] r_flash, w_flash_nxt, w_flash_inc;
  logic             w_key_edge;
  logic             w_abort;

  play_button_anim_edge_pulse #(
    .HIST_RST (1'b1)
  ) u_key_edge (
    .clk       (clk),
    .rst       (rst),
    .i_sig     (start_key),
    .o_pulse_c (w_key_edge)
  );

  assign w_cnt_inc   = r_cnt + CNT_W'(1);
  assign w_flash_inc = r_flash + CNT_W'(1);
  // Dropping enable cancels the animated states; DONE and WAIT_CLR finish on their own.
  assign w_abort = !enable && ((r_state == ST_SLIDE_IN) || (r_state == ST_BLINK) ||
                               (r_state == ST_CONFIRM));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_posx       <= X_W'(X_POS);
      r_posy       <= Y_W'(Y_START);
      r_isplay     <= 1'b0;
      r_game_start <= 1'b0;
      r_busy       <= 1'b0;
      r_cnt        <= '0;
      r_flash      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_posx       <= X_W'(X_POS);
      r_posy       <= w_posy_nxt;
      r_isplay     <= w_isplay_nxt;
      r_game_start <= w_game_start_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_cnt        <= w_cnt_nxt;
      r_flash      <= w_flash_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_posy_nxt       = r_posy;
    w_isplay_nxt     = r_isplay;
    w_game_start_nxt = 1'b0;
    w_cnt_nxt        = r_cnt;
    w_flash_nxt      = r_flash;

    case (r_state)
      ST_IDLE: begin
        w_isplay_nxt = 1'b0;
        w_posy_nxt   = Y_W'(Y_START);
        w_cnt_nxt    = '0;
        w_flash_nxt  = '0;
        if (enable) begin
          w_state_nxt  = ST_SLIDE_IN;
          w_isplay_nxt = 1'b1;
        end
      end
      ST_SLIDE_IN: begin
        if (frame_tick) begin
          w_posy_nxt = slide_next(r_posy, Y_W'(SLIDE_STEP), Y_W'(Y_TARGET));
          if (w_posy_nxt == Y_W'(Y_TARGET)) begin
            w_state_nxt  = ST_BLINK;
            w_cnt_nxt    = '0;
            w_isplay_nxt = 1'b1;
          end
        end
      end
      ST_BLINK: begin
        // A key edge wins over a coincident frame_tick, which is simply dropped.
        if (w_key_edge) begin
          w_state_nxt  = ST_CONFIRM;
          w_cnt_nxt    = '0;
          w_flash_nxt  = '0;
          w_isplay_nxt = 1'b1;
        end else if (frame_tick) begin
          if (w_cnt_inc == CNT_W'(BLINK_FRAMES)) begin
            w_isplay_nxt = ~r_isplay;
            w_cnt_nxt    = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      ST_CONFIRM: begin
        if (frame_tick) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_flash_inc == CNT_W'(FLASH_FRAMES)) begin
            w_isplay_nxt = ~r_isplay;
            w_flash_nxt  = '0;
          end else begin
            w_flash_nxt = w_flash_inc;
          end
          if (w_cnt_inc == CNT_W'(CONFIRM_FRAMES)) begin
            w_state_nxt      = ST_DONE;
            w_game_start_nxt = 1'b1;
            w_isplay_nxt     = 1'b0;
            w_cnt_nxt        = '0;
            w_flash_nxt      = '0;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt  = ST_WAIT_CLR;
        w_isplay_nxt = 1'b0;
      end
      ST_WAIT_CLR: begin
        w_isplay_nxt = 1'b0;
        if (!enable) begin
          w_state_nxt = ST_IDLE;
          w_posy_nxt  = Y_W'(Y_START);
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_posy_nxt   = Y_W'(Y_START);
        w_isplay_nxt = 1'b0;
        w_cnt_nxt    = '0;
        w_flash_nxt  = '0;
      end
    endcase

    if (w_abort) begin
      w_state_nxt      = ST_IDLE;
      w_posy_nxt       = Y_W'(Y_START);
      w_isplay_nxt     = 1'b0;
      w_game_start_nxt = 1'b0;
      w_cnt_nxt        = '0;
      w_flash_nxt      = '0;
    end
  end

  assign posx       = r_posx;
  assign posy       = r_posy;
  assign isplay     = r_isplay;
  assign game_start = r_game_start;
  assign busy       = r_busy;

endmodule

// File: tb/tb_play_button_anim.sv
// Bench for play_button_anim: vector table, directed sequences and random stimulus
// compared every cycle against a tick-counting reference model.
module tb_play_button_anim;

  localparam int GAP      = 10;
  localparam int EXP_POSX = 253;
  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  logic       clk = 1'b0;
  logic       rst, frame_tick, enable, start_key;
  logic [9:0] posx;
  logic [8:0] posy;
  logic       isplay, game_start, busy;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;
  int gs_seen = 0;

  play_button_anim dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .enable     (enable),
    .start_key  (start_key),
    .posx       (posx),
    .posy       (posy),
    .isplay     (isplay),
    .game_start (game_start),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference model: phase plus tick counts; outputs derived arithmetically.
  typedef enum int {M_IDLE, M_SLIDE, M_BLINK, M_CONF, M_DONE, M_WAIT} mphase_t;
  mphase_t m_phase    = M_IDLE;
  int      m_st       = 0;
  int      m_bt       = 0;
  int      m_ct       = 0;
  bit      m_prev_key = 1'b1;

  function automatic void model_step(bit r, bit e, bit t, bit k);
    bit kedge;
    kedge      = k && !m_prev_key;
    m_prev_key = r ? 1'b1 : k;
    if (r) begin
      m_phase = M_IDLE; m_st = 0; m_bt = 0; m_ct = 0;
    end else begin
      case (m_phase)
        M_IDLE:  if (e) begin m_phase = M_SLIDE; m_st = 0; end
        M_SLIDE: if (!e) m_phase = M_IDLE;
                 else if (t) begin
                   m_st++;
                   if (480 - 4 * m_st <= 300) begin m_phase = M_BLINK; m_bt = 0; end
                 end
        M_BLINK: if (!e) m_phase = M_IDLE;
                 else if (kedge) begin m_phase = M_CONF; m_ct = 0; end
                 else if (t) m_bt++;
        M_CONF:  if (!e) m_phase = M_IDLE;
                 else if (t) begin
                   m_ct++;
                   if (m_ct == 60) m_phase = M_DONE;
                 end
        M_DONE:  m_phase = M_WAIT;
        M_WAIT:  if (!e) m_phase = M_IDLE;
        default: m_phase = M_IDLE;
      endcase
    end
  endfunction

  function automatic int exp_posy();
    case (m_phase)
      M_IDLE:  return 480;
      M_SLIDE: return (480 - 4 * m_st < 300) ? 300 : 480 - 4 * m_st;
      default: return 300;
    endcase
  endfunction

  function automatic bit exp_isplay();
    case (m_phase)
      M_SLIDE: return 1'b1;
      M_BLINK: return ((m_bt / 30) % 2) == 0;
      M_CONF:  return ((m_ct / 4) % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic note_fail(input string msg);
    n_fail++;
    if (n_fail <= 20) $display("%s", msg);
  endtask

  task automatic check_model(input string name);
    bit e_isp, e_busy, e_gs;
    int e_posy;
    e_posy = exp_posy();
    e_isp  = exp_isplay();
    e_busy = (m_phase != M_IDLE);
    e_gs   = (m_phase == M_DONE);
    n_total++;
    if (int'(posx) == EXP_POSX && int'(posy) == e_posy && isplay == e_isp &&
        busy == e_busy && game_start == e_gs)
      n_pass++;
    else
      note_fail($sformatf("FAIL %s @%0t: got posx=%0d posy=%0d isplay=%0b busy=%0b game_start=%0b, want posx=%0d posy=%0d isplay=%0b busy=%0b game_start=%0b",
                          name, $time, posx, posy, isplay, busy, game_start,
                          EXP_POSX, e_posy, e_isp, e_busy, e_gs));
  endtask

  task automatic check_val(input string name, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else note_fail($sformatf("FAIL %s @%0t: got %0d, want %0d", name, $time, got, want));
  endtask

  task automatic cyc(input bit r, input bit e, input bit t, input bit k, input string name);
    rst = r; enable = e; frame_tick = t; start_key = k;
    @(posedge clk);
    #1;
    model_step(r, e, t, k);
    if (game_start) gs_seen++;
    check_model(name);
  endtask

  task automatic tick(input bit e, input bit k, input string name);
    cyc(L, e, H, k, name);
    repeat (GAP - 1) cyc(L, e, L, k, name);
  endtask

  task automatic enter_confirm();
    cyc(L, H, L, L, "ec_enable");
    repeat (45) tick(H, L, "ec_slide");
    cyc(L, H, L, H, "ec_press");
    check_val("ec_press_isplay", int'(isplay), 1);
  endtask

  typedef struct {
    bit r, e, t, k;
    int posy;
    bit isp, bsy, gs;
  } vec_t;
  vec_t vecs[10];

  int first300, ntog, gs0;
  int tog[3];
  bit prev_isp, re, rk;

  initial begin
    rst = 1'b1; enable = 1'b0; frame_tick = 1'b0; start_key = 1'b0;

    vecs[0] = '{H, L, L, L, 480, L, L, L};
    vecs[1] = '{L, H, L, L, 480, H, H, L};
    vecs[2] = '{L, H, H, L, 476, H, H, L};
    vecs[3] = '{L, H, L, L, 476, H, H, L};
    vecs[4] = '{L, H, H, L, 472, H, H, L};
    vecs[5] = '{L, L, L, L, 480, L, L, L};
    vecs[6] = '{L, L, H, L, 480, L, L, L};
    vecs[7] = '{L, H, L, L, 480, H, H, L};
    vecs[8] = '{H, H, L, L, 480, L, L, L};
    vecs[9] = '{L, H, L, L, 480, H, H, L};
    for (int i = 0; i < 10; i++) begin
      cyc(vecs[i].r, vecs[i].e, vecs[i].t, vecs[i].k, "table");
      n_total++;
      if (int'(posy) == vecs[i].posy && isplay == vecs[i].isp && busy == vecs[i].bsy &&
          game_start == vecs[i].gs && int'(posx) == EXP_POSX)
        n_pass++;
      else
        note_fail($sformatf("FAIL vec%0d: got posy=%0d isplay=%0b busy=%0b gs=%0b posx=%0d, want posy=%0d isplay=%0b busy=%0b gs=%0b",
                            i, posy, isplay, busy, game_start, posx,
                            vecs[i].posy, vecs[i].isp, vecs[i].bsy, vecs[i].gs));
    end

    // Slide-in with the key held from before BLINK.
    cyc(H, L, L, H, "rst_a");
    check_val("reset_posy", int'(posy), 480);
    cyc(L, H, L, H, "enable_a");
    check_val("enable_latency_isplay", int'(isplay), 1);
    first300 = -1;
    for (int i = 1; i <= 45; i++) begin
      tick(H, H, "slide_a");
      if (int'(posy) == 300 && first300 < 0) first300 = i;
    end
    check_val("slide_tick_count", first300, 45);

    // Blink with key still held: toggles at 30/60/90 prove CONFIRM was not taken.
    prev_isp = isplay; ntog = 0;
    for (int i = 1; i <= 95; i++) begin
      tick(H, H, "blink_hold");
      if (isplay != prev_isp) begin
        if (ntog < 3) tog[ntog] = i;
        ntog++;
        prev_isp = isplay;
      end
    end
    check_val("blink_toggles", ntog, 3);
    check_val("blink_tog1", tog[0], 30);
    check_val("blink_tog2", tog[1], 60);
    check_val("blink_tog3", tog[2], 90);
    check_val("blink_posy", int'(posy), 300);

    cyc(L, H, L, L, "release");
    cyc(L, H, L, H, "press");
    check_val("press_isplay", int'(isplay), 1);
    gs0 = gs_seen;
    repeat (59) tick(H, H, "confirm_a");
    check_val("confirm_no_early_start", gs_seen - gs0, 0);
    cyc(L, H, H, H, "confirm_last");
    check_val("done_game_start", int'(game_start), 1);
    check_val("done_isplay", int'(isplay), 0);
    cyc(L, H, L, H, "after_done");
    check_val("game_start_one_cycle", int'(game_start), 0);

    // WAIT_CLR holds with enable high, then re-arms only via enable low.
    gs0 = gs_seen;
    repeat (200) tick(H, 1'($urandom_range(0, 1)), "wait_clr");
    check_val("no_restart_pulses", gs_seen - gs0, 0);
    check_val("wait_clr_busy", int'(busy), 1);
    cyc(L, L, L, L, "disable");
    check_val("disable_busy", int'(busy), 0);
    check_val("disable_posy", int'(posy), 480);
    cyc(L, H, L, L, "reenable");
    check_val("reenable_posy", int'(posy), 480);
    check_val("reenable_isplay", int'(isplay), 1);

    // Key edge coincident with a tick on the last tick before a blink toggle.
    repeat (45) tick(H, L, "slide_b");
    repeat (29) tick(H, L, "blink_b");
    cyc(L, H, H, H, "key_and_tick");
    check_val("coincident_isplay", int'(isplay), 1);
    gs0 = gs_seen;
    repeat (59) tick(H, H, "confirm_b");
    check_val("coincident_tick_dropped", gs_seen - gs0, 0);
    cyc(L, H, H, H, "confirm_b_last");
    check_val("coincident_done", int'(game_start), 1);
    cyc(L, L, L, L, "to_wait");
    cyc(L, L, L, L, "to_idle");

    // enable dropped mid-CONFIRM.
    enter_confirm();
    repeat (20) tick(H, H, "confirm_c");
    cyc(L, L, L, H, "abort_enable");
    check_val("abort_en_posy", int'(posy), 480);
    check_val("abort_en_isplay", int'(isplay), 0);
    check_val("abort_en_busy", int'(busy), 0);
    gs0 = gs_seen;
    repeat (10) cyc(L, L, L, L, "abort_en_quiet");
    check_val("abort_en_no_start", gs_seen - gs0, 0);

    // rst mid-CONFIRM.
    enter_confirm();
    repeat (20) tick(H, H, "confirm_d");
    cyc(H, H, L, H, "abort_rst");
    check_val("abort_rst_posy", int'(posy), 480);
    check_val("abort_rst_isplay", int'(isplay), 0);
    check_val("abort_rst_busy", int'(busy), 0);
    cyc(L, H, L, H, "post_rst_enable");
    check_val("post_rst_slide", int'(isplay), 1);

    // Random stimulus against the model.
    re = 1'b1; rk = 1'b0;
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 299) == 0) re = ~re;
      if ($urandom_range(0, 39) == 0) rk = ~rk;
      cyc(1'($urandom_range(0, 1999) == 0), re, 1'($urandom_range(0, 2) == 0), rk, "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
